divider: RTL

DIVIDER -- requirements
Module: divider

---
 rtl/divider_pkg.sv | 15 +
 rtl/divider_datapath.sv | 81 ++++++++
 rtl/divider.sv | 100 ++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared types and helpers for the restoring divider.
package divider_pkg;

    // Controller states: IDLE accepts work, RUN iterates one quotient bit per clock.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width of an iteration counter that must hold the value n.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/divider_datapath.sv
// Operand, partial remainder and result registers of the restoring divider.
// do_init loads a new problem, do_step performs one restoring iteration and
// do_last (only together with do_step) publishes quotient and remainder.
module divider_datapath
    import divider_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         n_reset,
    input  logic         do_init,
    input  logic         do_step,
    input  logic         do_last,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    // The dividend register doubles as the quotient accumulator: each step
    // shifts a dividend bit out of the top and a quotient bit in at the bottom.
    logic [N-1:0] dvd_q;
    logic [N-1:0] dvs_q;
    logic [N:0]   prem_q;

    logic [N+1:0] shifted;
    logic [N+1:0] diff;
    logic         q_bit;
    logic [N:0]   prem_next;
    logic [N-1:0] dvd_next;

    // One restoring step: shift, trial-subtract, keep or restore.
    // prem_q is always below the divisor, so shifted stays below 2^(N+1) and
    // bit N+1 of the difference is a reliable sign bit.
    always_comb begin
        shifted   = {prem_q, dvd_q[N-1]};
        diff      = shifted - {2'b00, dvs_q};
        q_bit     = ~diff[N+1];
        prem_next = q_bit ? diff[N:0] : shifted[N:0];
        dvd_next  = {dvd_q[N-2:0], q_bit};
    end

    // Working registers: load on acceptance, advance on each RUN clock.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            dvd_q  <= '0;
            dvs_q  <= '0;
            prem_q <= '0;
        end else if (do_init) begin
            dvd_q  <= dividend;
            dvs_q  <= divisor;
            prem_q <= '0;
        end else if (do_step) begin
            dvd_q  <= dvd_next;
            prem_q <= prem_next;
        end
    end

    // Published results change only on the final step; they hold the previous
    // answer for the whole duration of a division.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            quotient  <= '0;
            remainder <= '0;
        end else if (do_step && do_last) begin
            quotient  <= dvd_next;
            remainder <= prem_next[N-1:0];
        end
    end

    // Divide-by-zero flag describes the most recently accepted problem.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            div_by_zero <= 1'b0;
        end else if (do_init) begin
            div_by_zero <= (divisor == '0);
        end
    end

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider: N clocks per division.
//
// Handshake: ready=1 means idle with valid results on quotient/remainder/
// div_by_zero. A rising edge with ready=1 and start=1 accepts dividend and
// divisor; ready then stays 0 for N clocks and rises on the same edge that
// publishes the new results. start while ready=0 is ignored, never queued.
// dbg_state exposes the controller state for observation.
module divider
    import divider_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         n_reset,
    input  logic         start,
    output logic         ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output state_t       dbg_state
);

    localparam int CW = count_width(N);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic          do_init;
    logic          do_step;
    logic          do_last;

    // Controller state register.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; the step that drives the counter to
    // zero is the last one and returns to IDLE.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        do_init = 1'b0;
        do_step = 1'b0;
        do_last = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    do_init = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                do_step = 1'b1;
                if (cnt_q == CW'(1)) begin
                    do_last = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Iteration counter: preset to N on acceptance, one decrement per step.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            cnt_q <= '0;
        end else if (do_init) begin
            cnt_q <= CW'(N);
        end else if (do_step) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign dbg_state = state_q;

    divider_datapath #(
        .N(N)
    ) u_datapath (
        .clock       (clock),
        .n_reset     (n_reset),
        .do_init     (do_init),
        .do_step     (do_step),
        .do_last     (do_last),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

endmodule
